// File: rtl/traffic_light_ped.sv
// Highway/farm-road intersection controller with pedestrian walk phase and night flash mode.
// Latency: inputs pass a 2-flop synchronizer; lights follow the state register by one cycle.
// No backpressure: the controller free-runs; requests are latched or sampled as levels.
module traffic_light_ped #(
  parameter int HWY_GREEN_MIN  = 8,
  parameter int YELLOW_TIME    = 3,
  parameter int ALL_RED_TIME   = 2,
  parameter int FARM_GREEN_MAX = 10,
  parameter int FLASH_HALF     = 4,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic [2:0] light_highway,
  output logic [2:0] light_farm,
  output logic       walk
);

  typedef enum logic [2:0] {
    HWY_GREEN   = 3'd0,
    HWY_YELLOW  = 3'd1,
    RED_A       = 3'd2,
    FARM_GREEN  = 3'd3,
    FARM_YELLOW = 3'd4,
    RED_B       = 3'd5,
    FLASH       = 3'd6
  } state_t;

  // Light encodings {red,yellow,green}
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  // Last timer value of each timed state (a state of duration D ends at timer D-1)
  localparam logic [CNT_W-1:0] HG_LAST = CNT_W'(HWY_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YL_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] FG_LAST = CNT_W'(FARM_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] FH_LAST = CNT_W'(FLASH_HALF - 1);

  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic             sensor_s;
  logic             ped_s;
  logic             flash_s;
  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             ped_pend;
  logic             ped_walk;
  logic             flash_on;

  assign sensor_s = sync2[2];
  assign ped_s    = sync2[1];
  assign flash_s  = sync2[0];

  // Two-flop synchronizers for the asynchronous request inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= {sensor, ped_req, flash_mode};
      sync2 <= sync1;
    end
  end

  // Phase sequencer, pedestrian latch and registered light decode of the current state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HWY_GREEN;
      timer         <= '0;
      ped_pend      <= 1'b0;
      ped_walk      <= 1'b0;
      flash_on      <= 1'b0;
      light_highway <= L_GRN;
      light_farm    <= L_RED;
      walk          <= 1'b0;
    end else begin
      // Request latch; the FARM_GREEN entry below overrides a coincident set
      if (ped_s) ped_pend <= 1'b1;

      case (state)
        HWY_GREEN: begin
          if (timer >= HG_LAST) begin
            if (sensor_s || ped_pend || flash_s) begin
              state <= HWY_YELLOW;
              timer <= '0;
            end else begin
              timer <= timer;  // saturate while holding green indefinitely
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        HWY_YELLOW: begin
          if (timer == YL_LAST) begin
            state <= RED_A;
            timer <= '0;
          end else timer <= timer + 1'b1;
        end
        RED_A: begin
          if (timer == AR_LAST) begin
            timer <= '0;
            if (flash_s) begin
              state    <= FLASH;
              flash_on <= 1'b1;
            end else begin
              state    <= FARM_GREEN;
              ped_walk <= ped_pend;  // walk phase decided once, at entry
              ped_pend <= 1'b0;
            end
          end else timer <= timer + 1'b1;
        end
        FARM_GREEN: begin
          if (flash_s || (timer == FG_LAST) || (!sensor_s && !ped_walk)) begin
            state <= FARM_YELLOW;
            timer <= '0;
          end else timer <= timer + 1'b1;
        end
        FARM_YELLOW: begin
          if (timer == YL_LAST) begin
            state <= RED_B;
            timer <= '0;
          end else timer <= timer + 1'b1;
        end
        RED_B: begin
          if (timer == AR_LAST) begin
            timer <= '0;
            if (flash_s) begin
              state    <= FLASH;
              flash_on <= 1'b1;
            end else begin
              state <= HWY_GREEN;
            end
          end else timer <= timer + 1'b1;
        end
        FLASH: begin
          if (!flash_s) begin
            state <= RED_B;
            timer <= '0;
          end else if (timer == FH_LAST) begin
            timer    <= '0;
            flash_on <= ~flash_on;
          end else timer <= timer + 1'b1;
        end
        default: begin
          // Unused code: recover through an all-red clearance
          state <= RED_B;
          timer <= '0;
        end
      endcase

      // Lights decode the state held during this cycle, so they trail it by one clock
      walk <= 1'b0;
      case (state)
        HWY_GREEN:   begin light_highway <= L_GRN; light_farm <= L_RED; end
        HWY_YELLOW:  begin light_highway <= L_YEL; light_farm <= L_RED; end
        FARM_GREEN:  begin
          light_highway <= L_RED;
          light_farm    <= L_GRN;
          walk          <= ped_walk;
        end
        FARM_YELLOW: begin light_highway <= L_RED; light_farm <= L_YEL; end
        FLASH: begin
          light_highway <= flash_on ? L_YEL : L_OFF;
          light_farm    <= flash_on ? L_RED : L_OFF;
        end
        default:     begin light_highway <= L_RED; light_farm <= L_RED; end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light_ped.sv
// Directed bench for traffic_light_ped at default parameters.
// Cycle n = interval after the n-th rising edge following reset release; samples at falling edges.
// Lights observed in cycle n reflect the controller state of cycle n-1.
module tb_traffic_light_ped;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sensor = 1'b0;
  logic       ped_req = 1'b0;
  logic       flash_mode = 1'b0;
  logic [2:0] light_highway;
  logic [2:0] light_farm;
  logic       walk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  traffic_light_ped dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sensor        (sensor),
    .ped_req       (ped_req),
    .flash_mode    (flash_mode),
    .light_highway (light_highway),
    .light_farm    (light_farm),
    .walk          (walk)
  );

  always #5 clk = ~clk;

  task automatic check_lights(input string tag, input logic [2:0] exp_h,
                              input logic [2:0] exp_f, input logic exp_w);
    tests++;
    assert ({light_highway, light_farm, walk} === {exp_h, exp_f, exp_w})
    else begin
      fails++;
      $error("FAIL %s cyc=%0d: got hwy=%b farm=%b walk=%b, expected hwy=%b farm=%b walk=%b",
             tag, cyc, light_highway, light_farm, walk, exp_h, exp_f, exp_w);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Safety invariant checked on every falling edge throughout the run
  always @(negedge clk) begin
    logic h_ok, f_ok, dark_pair, conflict;
    h_ok      = (light_highway inside {3'b001, 3'b010, 3'b100, 3'b000});
    f_ok      = (light_farm inside {3'b001, 3'b010, 3'b100, 3'b000});
    dark_pair = ((light_highway == 3'b000) == (light_farm == 3'b000));
    conflict  = (light_highway != 3'b100) && (light_farm != 3'b100) &&
                !((light_highway == 3'b000) && (light_farm == 3'b000));
    tests++;
    assert (h_ok && f_ok && dark_pair && !conflict)
    else begin
      fails++;
      $error("FAIL safety cyc=%0d: got hwy=%b farm=%b, expected non-conflicting legal encodings",
             cyc, light_highway, light_farm);
    end
  end

  initial begin
    // Idle: no requests keeps highway green forever
    sensor = 0; ped_req = 0; flash_mode = 0;
    do_reset();
    check_lights("idle_reset", 3'b001, 3'b100, 1'b0);
    for (int i = 1; i <= 100; i++) begin
      goto(i);
      check_lights("idle_hold", 3'b001, 3'b100, 1'b0);
    end

    // Vehicle on farm road from reset: minimum green, then full farm cycle capped at max
    sensor = 1;
    do_reset();
    check_lights("veh_c0", 3'b001, 3'b100, 1'b0);
    goto(8);  check_lights("veh_c8_still_green", 3'b001, 3'b100, 1'b0);
    goto(9);  check_lights("veh_hwy_yellow", 3'b010, 3'b100, 1'b0);
    goto(11); check_lights("veh_yellow_last", 3'b010, 3'b100, 1'b0);
    goto(12); check_lights("veh_red_a", 3'b100, 3'b100, 1'b0);
    goto(14); check_lights("veh_farm_green", 3'b100, 3'b001, 1'b0);
    goto(23); check_lights("veh_farm_green_last", 3'b100, 3'b001, 1'b0);
    goto(24); check_lights("veh_farm_yellow", 3'b100, 3'b010, 1'b0);
    goto(27); check_lights("veh_red_b", 3'b100, 3'b100, 1'b0);
    goto(28); sensor = 0;
    goto(29); check_lights("veh_back_green", 3'b001, 3'b100, 1'b0);
    goto(60); check_lights("veh_hold_green", 3'b001, 3'b100, 1'b0);

    // Single pedestrian pulse: walk for the full farm-green maximum, then no repeat
    sensor = 0;
    do_reset();
    goto(20); ped_req = 1;
    goto(21); ped_req = 0;
    goto(24); check_lights("ped_still_green", 3'b001, 3'b100, 1'b0);
    goto(25); check_lights("ped_hwy_yellow", 3'b010, 3'b100, 1'b0);
    goto(29); check_lights("ped_red_a", 3'b100, 3'b100, 1'b0);
    goto(30); check_lights("ped_walk_on", 3'b100, 3'b001, 1'b1);
    goto(39); check_lights("ped_walk_last", 3'b100, 3'b001, 1'b1);
    goto(40); check_lights("ped_walk_off", 3'b100, 3'b010, 1'b0);
    goto(45); check_lights("ped_back_green", 3'b001, 3'b100, 1'b0);
    goto(60); check_lights("ped_no_repeat", 3'b001, 3'b100, 1'b0);

    // Flash requested during farm green
    sensor = 1;
    do_reset();
    goto(15); flash_mode = 1;
    goto(19); check_lights("fl_farm_yellow", 3'b100, 3'b010, 1'b0);
    goto(22); check_lights("fl_red_b", 3'b100, 3'b100, 1'b0);
    goto(24); check_lights("fl_lit_first", 3'b010, 3'b100, 1'b0);
    goto(27); check_lights("fl_lit_last", 3'b010, 3'b100, 1'b0);
    goto(28); check_lights("fl_dark_first", 3'b000, 3'b000, 1'b0);
    goto(31); check_lights("fl_dark_last", 3'b000, 3'b000, 1'b0);
    goto(32); check_lights("fl_lit_again", 3'b010, 3'b100, 1'b0);
    goto(40); flash_mode = 0; sensor = 0;
    goto(44); check_lights("fl_exit_red_b", 3'b100, 3'b100, 1'b0);
    goto(45); check_lights("fl_exit_red_b2", 3'b100, 3'b100, 1'b0);
    goto(46); check_lights("fl_exit_green", 3'b001, 3'b100, 1'b0);

    // Asynchronous reset during farm yellow, then a normal restart
    sensor = 1;
    do_reset();
    goto(24); check_lights("rst_pre_farm_yellow", 3'b100, 3'b010, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_lights("rst_async", 3'b001, 3'b100, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    goto(8); check_lights("rst_resume_full_min", 3'b001, 3'b100, 1'b0);
    goto(9); check_lights("rst_resume_yellow", 3'b010, 3'b100, 1'b0);

    // Random traffic exercising the safety invariant
    sensor = 0; ped_req = 0; flash_mode = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      sensor  = 1'($urandom_range(0, 1));
      ped_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 59) == 0) flash_mode = ~flash_mode;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
